// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared memory width codes, LSU state and cause encodings.
// Also holds the RAM direction constants used by both the LSU and the RAM.
package lsu_ctrl_pkg;
    localparam int DATA_WIDTH = 64;
    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_D  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101,
        MEM_WU = 3'b110
    } mem_wid_e;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} lsu_state_e;
    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_MIS_LD = 2'b01,
        CAUSE_MIS_ST = 2'b10,
        CAUSE_FAULT  = 2'b11
    } lsu_cause_e;
endpackage

// File: rtl/lsu_ctrl_addr_check.sv
// lsu_addr_check: combinational range/alignment check of a memory access.
//   addr  in  DATA_WIDTH  effective byte address
//   wid   in  3           mem_wid_e width code
//   we    in  1           1=store, 0=load
//   exc   out 1           access must not reach the RAM
//   cause out 2           lsu_cause_e code (fault beats misalignment)
module lsu_addr_check
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [2:0]            wid,
    input  logic                  we,
    output logic                  exc,
    output logic [1:0]            cause
);
    logic fault;
    logic mis;
    // Unsigned widths and 3'b111 have no store form; bits above the RAM are out of range.
    assign fault = (|addr[DATA_WIDTH-1:ADDR_W]) || (wid == 3'b111) || (we && wid[2]);
    // wid[1:0] encodes log2 of the access size for every legal code.
    assign mis = (wid[1:0] == 2'd1) ? addr[0] :
                 (wid[1:0] == 2'd2) ? |addr[1:0] :
                 (wid[1:0] == 2'd3) ? |addr[2:0] : 1'b0;
    assign exc = fault || mis;
    assign cause = fault ? CAUSE_FAULT :
                   mis   ? (we ? CAUSE_MIS_ST : CAUSE_MIS_LD) : CAUSE_NONE;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store stage in front of the byte-addressed data RAM.
//   clk, rst_n                clock, async active-low reset
//   req_*                     execute request (valid/ready), we, wid, addr, wdata, rd
//   flush_i                   drop the in-flight response
//   ram_*                     RAM port, enabled for exactly one cycle per legal access
//   resp_*                    writeback response (valid/ready) with data, rd, exception
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_wid_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [RD_W-1:0]       req_rd_i,
    input  logic                  flush_i,
    output logic                  ram_en_o,
    output logic                  ram_enwr_o,
    output logic [2:0]            ram_wid_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [RD_W-1:0]       resp_rd_o,
    output logic                  resp_exc_o,
    output logic [1:0]            resp_cause_o
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_CAPT  = CAPT;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0] state;
    logic       we_q;
    logic       chk_exc;
    logic [1:0] chk_cause;

    lsu_addr_check #(.ADDR_W(ADDR_W)) u_check (
        .addr  (req_addr_i),
        .wid   (req_wid_i),
        .we    (req_we_i),
        .exc   (chk_exc),
        .cause (chk_cause)
    );

    assign req_ready_o  = state == S_IDLE;
    assign ram_en_o     = state == S_ISSUE;
    assign ram_enwr_o   = ram_en_o ? ~we_q : MEM_READ;
    assign resp_valid_o = state == S_RESP;

    // The RAM-side latches double as the request latch: they hold outside ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            ram_wid_o    <= '0;
            ram_addr_o   <= '0;
            ram_data_o   <= '0;
            resp_rdata_o <= '0;
            resp_rd_o    <= '0;
            resp_exc_o   <= 1'b0;
            resp_cause_o <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid_i) begin
                    we_q         <= req_we_i;
                    ram_wid_o    <= req_wid_i;
                    ram_addr_o   <= req_addr_i[ADDR_W-1:0];
                    ram_data_o   <= req_wdata_i;
                    resp_rdata_o <= '0;
                    resp_rd_o    <= req_we_i ? '0 : req_rd_i;
                    resp_exc_o   <= chk_exc;
                    resp_cause_o <= chk_cause;
                    state        <= chk_exc ? S_RESP : S_ISSUE;
                end
                // The RAM access of this cycle completes even when flushed.
                S_ISSUE: state <= flush_i ? S_IDLE : (we_q ? S_RESP : S_CAPT);
                S_CAPT: begin
                    resp_rdata_o <= ram_data_i;
                    state        <= flush_i ? S_IDLE : S_RESP;
                end
                S_RESP: if (flush_i || resp_ready_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
